fifo_sync_flags: RTL and testbench

//  Parametrised single-clock FIFO; successor of the fixed 8x8 push/pop FIFO.

---
 rtl/fifo_sync_flags.sv | 120 ++++++++++++
 tb/tb_fifo_sync_flags.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fifo_sync_flags.sv
// Parametrised single-clock FIFO with any depth, a fill-level output, almost-full/empty flags,
// sticky overflow/underflow and push+pop while full. FIFO_ONESHOT_EN turns push/pop into rising-edge requests.
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [DATA_WIDTH-1:0]        data_input,
  input  logic                         push,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         full_out,
  output logic                         empty_out,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]         level_reg, level_next;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;
  logic [DATA_WIDTH-1:0] data_out_reg;

  // Bit 0 is push, bit 1 is pop.
  logic [1:0] req;
  logic [1:0] req_q;
  logic       push_acc, pop_acc;
  logic       full_int, empty_int;

  assign req = {pop, push};

`ifdef FIFO_ONESHOT_EN
  // Previous-cycle copy resets to 0, so a request held through reset release counts as an edge.
  logic [1:0] req_d_reg;

  always_ff @(posedge clk) begin
    if (reset) req_d_reg <= '0;
    else       req_d_reg <= req;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    assign req_q[gi] = req[gi] & ~req_d_reg[gi];
  end
`else
  for (genvar gi = 0; gi < 2; gi++) begin : g_level
    assign req_q[gi] = req[gi];
  end
`endif

  assign full_int  = (level_reg == FULL_LVL);
  assign empty_int = (level_reg == '0);
  assign pop_acc   = req_q[1] & ~empty_int;
  // A pop in the same cycle frees the slot, so a push while full still goes in.
  assign push_acc  = req_q[0] & (~full_int | pop_acc);

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    level_next     = level_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (push_acc) wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    if (pop_acc)  rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;

    if (push_acc && !pop_acc)      level_next = level_reg + 1'b1;
    else if (pop_acc && !push_acc) level_next = level_reg - 1'b1;

    if (req_q[0] && !push_acc) overflow_next  = 1'b1;
    if (req_q[1] && !pop_acc)  underflow_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      data_out_reg  <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
      if (pop_acc) data_out_reg <= mem[rd_ptr_reg];
    end
  end

  // Storage is never cleared; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_acc && !reset && !clear) mem[wr_ptr_reg] <= data_input;
  end

  assign data_out     = data_out_reg;
  assign level        = level_reg;
  assign full_out     = full_int;
  assign empty_out    = empty_int;
  assign almost_full  = (int'(level_reg) >= AF_THRESH);
  assign almost_empty = (int'(level_reg) <= AE_THRESH);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Bench for fifo_sync_flags (DEPTH=5, AF=4, AE=1): vector table for flags/level,
// scoreboard queue for read data; FIFO_ONESHOT_EN selects the edge-request sequence.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       reset, clear, push, pop;
  logic [7:0] data_input;
  logic [7:0] data_out;
  logic       full_out, empty_out, almost_full, almost_empty, overflow, underflow;
  logic [2:0] level;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       psh;
    logic       pp;
    logic [7:0] din;
    int         lvl;
    logic       ovf;
    logic       udf;
    logic       chk;
    logic [7:0] dout;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_q[$];

  fifo_sync_flags #(
    .DATA_WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .data_input(data_input),
    .push(push), .pop(pop), .data_out(data_out), .full_out(full_out),
    .empty_out(empty_out), .almost_full(almost_full), .almost_empty(almost_empty),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic clr, input logic psh, input logic pp,
                     input logic [7:0] din, input int lvl, input logic ovf, input logic udf,
                     input logic chk, input logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.clr = clr; v.psh = psh; v.pp = pp; v.din = din;
    v.lvl = lvl; v.ovf = ovf; v.udf = udf; v.chk = chk; v.dout = dout;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic clr, input logic psh, input logic pp,
                       input logic [7:0] din);
    reset = rst; clear = clr; push = psh; pop = pp; data_input = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input int idx, input int lvl, input logic ovf, input logic udf);
    check("level", idx, int'(level), lvl);
    check("full_out", idx, int'(full_out), int'(lvl == 5));
    check("empty_out", idx, int'(empty_out), int'(lvl == 0));
    check("almost_full", idx, int'(almost_full), int'(lvl >= 4));
    check("almost_empty", idx, int'(almost_empty), int'(lvl <= 1));
    check("overflow", idx, int'(overflow), int'(ovf));
    check("underflow", idx, int'(underflow), int'(udf));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; data_input = 8'h00;
    @(posedge clk);
    #1;

`ifndef FIFO_ONESHOT_EN
    // Reset state
    add(1,0,0,0,8'h00, 0,0,0, 1,8'h00);
    // Fill 0x11..0x55, then drain in order
    for (int i = 1; i <= 5; i++) add(0,0,1,0,8'(i*17), i,0,0, 0,8'h00);
    for (int i = 1; i <= 5; i++) add(0,0,0,1,8'h00, 5-i,0,0, 1,8'(i*17));
    // Overflow: 0x66 dropped
    for (int i = 1; i <= 5; i++) add(0,0,1,0,8'(i*17), i,0,0, 0,8'h00);
    add(0,0,1,0,8'h66, 5,1,0, 0,8'h00);
    for (int i = 1; i <= 5; i++) add(0,0,0,1,8'h00, 5-i,1,0, 1,8'(i*17));
    add(1,0,0,0,8'h00, 0,0,0, 1,8'h00);
    // Push+pop while full, then wrap at level 2
    for (int i = 1; i <= 5; i++) add(0,0,1,0,8'(i*17), i,0,0, 0,8'h00);
    add(0,0,1,1,8'h77, 5,0,0, 1,8'h11);
    add(0,0,0,1,8'h00, 4,0,0, 1,8'h22);
    add(0,0,0,1,8'h00, 3,0,0, 1,8'h33);
    add(0,0,0,1,8'h00, 2,0,0, 1,8'h44);
    add(0,0,1,1,8'h80, 2,0,0, 1,8'h55);
    add(0,0,1,1,8'h81, 2,0,0, 1,8'h77);
    for (int i = 2; i < 12; i++) add(0,0,1,1,8'(8'h80 + i), 2,0,0, 1,8'(8'h80 + i - 2));
    add(0,0,0,1,8'h00, 1,0,0, 1,8'h8A);
    add(0,0,0,1,8'h00, 0,0,0, 1,8'h8B);
    // Push+pop while empty: pop rejected
    add(0,0,1,1,8'hA5, 1,0,1, 1,8'h8B);
    add(0,0,0,1,8'h00, 0,0,1, 1,8'hA5);
    add(0,0,0,1,8'h00, 0,0,1, 1,8'hA5);
    // Clear with push at level 3, then reset mid-stream with push+pop
    add(0,0,1,0,8'h01, 1,0,1, 0,8'h00);
    add(0,0,1,0,8'h02, 2,0,1, 0,8'h00);
    add(0,0,1,0,8'h03, 3,0,1, 0,8'h00);
    add(0,1,1,0,8'h04, 0,0,0, 1,8'h00);
    add(0,0,1,0,8'h05, 1,0,0, 0,8'h00);
    add(0,0,1,0,8'h06, 2,0,0, 0,8'h00);
    add(1,0,1,1,8'h07, 0,0,0, 1,8'h00);
    add(0,0,0,1,8'h00, 0,0,1, 1,8'h00);
    add(0,0,1,0,8'h08, 1,0,1, 0,8'h00);
    add(0,0,0,1,8'h00, 0,0,1, 1,8'h08);

    foreach (tbl[k]) begin
      if (tbl[k].chk) exp_q.push_back(tbl[k].dout);
      drive(tbl[k].rst, tbl[k].clr, tbl[k].psh, tbl[k].pp, tbl[k].din);
      $display("[TB] vec %0d rst=%0b clr=%0b push=%0b pop=%0b din=%02h -> level=%0d dout=%02h ovf=%0b udf=%0b",
               k, tbl[k].rst, tbl[k].clr, tbl[k].psh, tbl[k].pp, tbl[k].din,
               level, data_out, overflow, underflow);
      check_state(k, tbl[k].lvl, tbl[k].ovf, tbl[k].udf);
      if (tbl[k].chk) check("data_out", k, int'(data_out), int'(exp_q.pop_front()));
    end
`else
    // Held requests are accepted once each
    drive(0,0,1,0,8'h3C);
    check_state(0, 1, 0, 0);
    for (int i = 1; i < 4; i++) begin
      drive(0,0,1,0,8'hC3);
      $display("[TB] oneshot push hold cycle %0d -> level=%0d", i, level);
      check_state(i, 1, 0, 0);
    end
    exp_q.push_back(8'h3C);
    drive(0,0,0,1,8'h00);
    check_state(4, 0, 0, 0);
    check("data_out", 4, int'(data_out), int'(exp_q.pop_front()));
    for (int i = 5; i < 7; i++) begin
      drive(0,0,0,1,8'h00);
      $display("[TB] oneshot pop hold cycle %0d -> level=%0d udf=%0b", i, level, underflow);
      check_state(i, 0, 0, 0);
      check("data_out_hold", i, int'(data_out), 32'h3C);
    end
`endif

    drive(0,0,0,0,8'h00);
    check("queue_drained", 999, exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
